mem_request_scheduler: RTL and testbench

Round-robin scheduler that shares the single DDR3 MIG application (UI) port among `NUM_CORES` MIPS cores. It sits between the per-core memory request ports and the external memory controller, in the `ui_clk` domain. It latches one core's 32-bit word request, sequences the read or write command/data handshakes, and routes a one-cycle response back to the granted core. It replaces the ad-hoc core-select/state coupling in the processor top level.

---
 rtl/mem_request_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_mem_request_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_request_scheduler.sv
// Round-robin scheduler sharing one DDR3 MIG UI port among NUM_CORES cores.
// One 32-bit word request is latched per grant, sequenced through the MIG handshakes, answered.
module mem_request_scheduler #(
  parameter int unsigned NUM_CORES      = 16,
  parameter int unsigned ADDR_WIDTH     = 28,
  parameter int unsigned APP_DATA_WIDTH = 128
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init_calib_complete,
  input  logic [NUM_CORES-1:0]         core_req,
  input  logic [NUM_CORES-1:0]         core_wren,
  input  logic [32*NUM_CORES-1:0]      core_addr,
  input  logic [32*NUM_CORES-1:0]      core_wdata,
  output logic [NUM_CORES-1:0]         core_resp,
  output logic [31:0]                  core_rdata,
  output logic [$clog2(NUM_CORES)-1:0] grant_id,
  output logic                         busy,
  output logic                         app_en,
  output logic [2:0]                   app_cmd,
  output logic [ADDR_WIDTH-1:0]        app_addr,
  output logic                         app_wdf_wren,
  output logic                         app_wdf_end,
  output logic [APP_DATA_WIDTH-1:0]    app_wdf_data,
  output logic [APP_DATA_WIDTH/8-1:0]  app_wdf_mask,
  input  logic                         app_rdy,
  input  logic                         app_wdf_rdy,
  input  logic                         app_rd_data_valid,
  input  logic [APP_DATA_WIDTH-1:0]    app_rd_data
);
  localparam int unsigned IdW = $clog2(NUM_CORES);

  typedef enum logic [2:0] {StInit, StArb, StIssueRd, StWaitRd, StIssueWr, StResp} state_e;

  state_e                      r_state, w_state_nxt;
  logic [IdW-1:0]              r_rr_ptr, w_rr_ptr_nxt;
  logic [IdW-1:0]              r_grant_id, w_grant_id_nxt;
  logic                        r_busy, w_busy_nxt;
  logic                        r_app_en, w_app_en_nxt;
  logic [2:0]                  r_app_cmd, w_app_cmd_nxt;
  logic [ADDR_WIDTH-1:0]       r_app_addr, w_app_addr_nxt;
  logic                        r_wdf_wren, w_wdf_wren_nxt;
  logic [APP_DATA_WIDTH-1:0]   r_wdf_data, w_wdf_data_nxt;
  logic [APP_DATA_WIDTH/8-1:0] r_wdf_mask, w_wdf_mask_nxt;
  logic [1:0]                  r_lane, w_lane_nxt;
  logic [NUM_CORES-1:0]        r_core_resp, w_core_resp_nxt;
  logic [31:0]                 r_core_rdata, w_core_rdata_nxt;

  logic [31:0]                 w_addr_arr  [NUM_CORES];
  logic [31:0]                 w_wdata_arr [NUM_CORES];
  logic                        w_found;
  logic [IdW-1:0]              w_pick;
  logic [IdW-1:0]              w_ptr_inc;
  logic [31:0]                 w_sel_addr;
  logic [APP_DATA_WIDTH/8-1:0] w_sel_mask;
  logic [31:0]                 w_rd_word;
  logic                        w_unused_addr_bits;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign w_addr_arr[g]  = core_addr[32*g +: 32];
    assign w_wdata_arr[g] = core_wdata[32*g +: 32];
  end

  // First requester at or after r_rr_ptr, wrapping modulo NUM_CORES.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      if (!w_found && core_req[IdW'((32'(r_rr_ptr) + k) % NUM_CORES)]) begin
        w_found = 1'b1;
        w_pick  = IdW'((32'(r_rr_ptr) + k) % NUM_CORES);
      end
    end
  end

  assign w_ptr_inc          = (w_pick == IdW'(NUM_CORES - 1)) ? '0 : w_pick + 1'b1;
  assign w_sel_addr         = w_addr_arr[w_pick];
  assign w_unused_addr_bits = ^{w_sel_addr[1:0], w_sel_addr[31:ADDR_WIDTH+1]};

  // Active-high byte mask: only the selected 32-bit lane is written.
  always_comb begin
    case (w_sel_addr[3:2])
      2'd0:    w_sel_mask = 16'hFFF0;
      2'd1:    w_sel_mask = 16'hFF0F;
      2'd2:    w_sel_mask = 16'hF0FF;
      default: w_sel_mask = 16'h0FFF;
    endcase
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_rd_word = app_rd_data[31:0];
      2'd1:    w_rd_word = app_rd_data[63:32];
      2'd2:    w_rd_word = app_rd_data[95:64];
      default: w_rd_word = app_rd_data[127:96];
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_grant_id_nxt   = r_grant_id;
    w_busy_nxt       = r_busy;
    w_app_en_nxt     = r_app_en;
    w_app_cmd_nxt    = r_app_cmd;
    w_app_addr_nxt   = r_app_addr;
    w_wdf_wren_nxt   = r_wdf_wren;
    w_wdf_data_nxt   = r_wdf_data;
    w_wdf_mask_nxt   = r_wdf_mask;
    w_lane_nxt       = r_lane;
    w_core_resp_nxt  = '0;
    w_core_rdata_nxt = r_core_rdata;
    case (r_state)
      StInit: begin
        if (init_calib_complete) w_state_nxt = StArb;
      end
      StArb: begin
        if (w_found) begin
          w_grant_id_nxt = w_pick;
          w_rr_ptr_nxt   = w_ptr_inc;
          w_busy_nxt     = 1'b1;
          w_app_en_nxt   = 1'b1;
          w_app_addr_nxt = {w_sel_addr[ADDR_WIDTH:4], 3'b000};
          w_lane_nxt     = w_sel_addr[3:2];
          w_wdf_data_nxt = {4{w_wdata_arr[w_pick]}};
          w_wdf_mask_nxt = w_sel_mask;
          if (core_wren[w_pick]) begin
            w_app_cmd_nxt  = 3'b000;
            w_wdf_wren_nxt = 1'b1;
            w_state_nxt    = StIssueWr;
          end else begin
            w_app_cmd_nxt  = 3'b001;
            w_state_nxt    = StIssueRd;
          end
        end
      end
      StIssueRd: begin
        if (r_app_en && app_rdy) begin
          w_app_en_nxt = 1'b0;
          w_state_nxt  = StWaitRd;
        end
      end
      StWaitRd: begin
        if (app_rd_data_valid) begin
          w_core_rdata_nxt            = w_rd_word;
          w_core_resp_nxt[r_grant_id] = 1'b1;
          w_state_nxt                 = StResp;
        end
      end
      StIssueWr: begin
        // Command and data channels are accepted independently, in either order.
        if (app_rdy) w_app_en_nxt = 1'b0;
        if (app_wdf_rdy) w_wdf_wren_nxt = 1'b0;
        if ((!r_app_en || app_rdy) && (!r_wdf_wren || app_wdf_rdy)) begin
          w_core_resp_nxt[r_grant_id] = 1'b1;
          w_state_nxt                 = StResp;
        end
      end
      StResp: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = StArb;
      end
      default: w_state_nxt = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= StInit;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_busy       <= 1'b0;
      r_app_en     <= 1'b0;
      r_app_cmd    <= '0;
      r_app_addr   <= '0;
      r_wdf_wren   <= 1'b0;
      r_wdf_data   <= '0;
      r_wdf_mask   <= '0;
      r_lane       <= '0;
      r_core_resp  <= '0;
      r_core_rdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_grant_id   <= w_grant_id_nxt;
      r_busy       <= w_busy_nxt;
      r_app_en     <= w_app_en_nxt;
      r_app_cmd    <= w_app_cmd_nxt;
      r_app_addr   <= w_app_addr_nxt;
      r_wdf_wren   <= w_wdf_wren_nxt;
      r_wdf_data   <= w_wdf_data_nxt;
      r_wdf_mask   <= w_wdf_mask_nxt;
      r_lane       <= w_lane_nxt;
      r_core_resp  <= w_core_resp_nxt;
      r_core_rdata <= w_core_rdata_nxt;
    end
  end

  assign core_resp    = r_core_resp;
  assign core_rdata   = r_core_rdata;
  assign grant_id     = r_grant_id;
  assign busy         = r_busy;
  assign app_en       = r_app_en;
  assign app_cmd      = r_app_cmd;
  assign app_addr     = r_app_addr;
  assign app_wdf_wren = r_wdf_wren;
  assign app_wdf_end  = r_wdf_wren;
  assign app_wdf_data = r_wdf_data;
  assign app_wdf_mask = r_wdf_mask;

endmodule

// File: tb/tb_mem_request_scheduler.sv
// Directed plus randomized bench for mem_request_scheduler with a transaction-level model:
// round-robin pick, address/lane arithmetic and handshake timing computed from the rules.
module tb_mem_request_scheduler;
  localparam int N  = 16;
  localparam int AW = 28;

  logic              clk = 1'b0;
  logic              reset;
  logic              init_calib_complete;
  logic [N-1:0]      core_req;
  logic [N-1:0]      core_wren;
  logic [32*N-1:0]   core_addr;
  logic [32*N-1:0]   core_wdata;
  logic [N-1:0]      core_resp;
  logic [31:0]       core_rdata;
  logic [3:0]        grant_id;
  logic              busy;
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [AW-1:0]     app_addr;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [127:0]      app_wdf_data;
  logic [15:0]       app_wdf_mask;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic              app_rd_data_valid;
  logic [127:0]      app_rd_data;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  int got;

  always #5 clk = ~clk;

  mem_request_scheduler #(
    .NUM_CORES      (N),
    .ADDR_WIDTH     (AW),
    .APP_DATA_WIDTH (128)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .init_calib_complete (init_calib_complete),
    .core_req            (core_req),
    .core_wren           (core_wren),
    .core_addr           (core_addr),
    .core_wdata          (core_wdata),
    .core_resp           (core_resp),
    .core_rdata          (core_rdata),
    .grant_id            (grant_id),
    .busy                (busy),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_rdy             (app_rdy),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data         (app_rd_data)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return N;
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      core_addr[32*i +: 32]  = $urandom();
      core_wdata[32*i +: 32] = $urandom();
    end
    core_wren = N'($urandom());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_resp"}, core_resp, 0);
    chk({tag, "_rdata"}, core_rdata, 0);
    chk({tag, "_grant"}, grant_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_en"}, app_en, 0);
    chk({tag, "_cmd"}, app_cmd, 0);
    chk({tag, "_addr"}, app_addr, 0);
    chk({tag, "_wren"}, app_wdf_wren, 0);
    chk({tag, "_end"}, app_wdf_end, 0);
    chk({tag, "_data"}, app_wdf_data, 0);
    chk({tag, "_mask"}, app_wdf_mask, 0);
  endtask

  // Starts with the DUT about to sample in ARB; ends with the DUT back in ARB.
  task automatic run_txn(input logic [N-1:0] req, input int dc, input int dd, input int dv,
                         input logic [127:0] rd, output int gid);
    int            e;
    int            lane;
    int            mx;
    logic [31:0]   ea;
    logic [31:0]   ewd;
    logic          ewr;
    logic [AW-1:0] eaddr;
    logic [15:0]   emask;
    logic [127:0]  edata;
    logic [N-1:0]  oh;
    core_req          = req;
    app_rdy           = 1'b0;
    app_wdf_rdy       = 1'b0;
    app_rd_data_valid = 1'b0;
    e     = model_pick(req, m_ptr);
    ea    = core_addr[32*e +: 32];
    ewd   = core_wdata[32*e +: 32];
    ewr   = core_wren[e];
    lane  = int'((ea / 4) % 4);
    eaddr = AW'((ea / 16) * 8);
    emask = 16'hFFFF ^ (16'hF << (4 * lane));
    edata = {4{ewd}};
    oh    = '0;
    oh[e] = 1'b1;
    tick();
    gid = int'(grant_id);
    chk("grant_id", grant_id, e);
    chk("grant_busy", busy, 1);
    chk("grant_en", app_en, 1);
    chk("grant_cmd", app_cmd, ewr ? 0 : 1);
    chk("grant_addr", app_addr, eaddr);
    chk("grant_resp", core_resp, 0);
    if (ewr) begin
      chk("grant_wren", app_wdf_wren, 1);
      chk("grant_end", app_wdf_end, 1);
      chk("grant_data", app_wdf_data, edata);
      chk("grant_mask", app_wdf_mask, emask);
    end
    m_ptr = (e + 1) % N;
    scramble();
    if (ewr) begin
      mx = (dc > dd) ? dc : dd;
      for (int c = 0; c <= mx; c++) begin
        if (c > 0) begin
          chk("wr_en", app_en, c <= dc);
          chk("wr_wren", app_wdf_wren, c <= dd);
          chk("wr_end", app_wdf_end, c <= dd);
          chk("wr_data", app_wdf_data, edata);
          chk("wr_mask", app_wdf_mask, emask);
          chk("wr_addr", app_addr, eaddr);
          chk("wr_early_resp", core_resp, 0);
        end
        app_rdy     = (c >= dc);
        app_wdf_rdy = (c >= dd);
        tick();
      end
      app_rdy     = 1'b0;
      app_wdf_rdy = 1'b0;
      chk("wr_resp", core_resp, oh);
      chk("wr_en_done", app_en, 0);
      chk("wr_wren_done", app_wdf_wren, 0);
      chk("wr_busy_resp", busy, 1);
    end else begin
      for (int c = 0; c <= dc; c++) begin
        if (c > 0) begin
          chk("rd_en_stall", app_en, 1);
          chk("rd_addr_stall", app_addr, eaddr);
          chk("rd_early_resp", core_resp, 0);
        end
        app_rdy = (c == dc);
        tick();
      end
      app_rdy = 1'b0;
      chk("rd_en_drop", app_en, 0);
      for (int w = 0; w < dv; w++) begin
        tick();
        chk("rd_wait_resp", core_resp, 0);
        chk("rd_wait_busy", busy, 1);
      end
      app_rd_data       = rd;
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      app_rd_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
      chk("rd_resp", core_resp, oh);
      chk("rd_rdata", core_rdata, 32'(rd >> (32 * lane)));
      chk("rd_busy_resp", busy, 1);
    end
    tick();
    chk("post_resp", core_resp, 0);
    chk("post_busy", busy, 0);
    chk("post_en", app_en, 0);
  endtask

  initial begin
    reset               = 1'b1;
    init_calib_complete = 1'b0;
    core_req            = '0;
    core_wren           = '0;
    core_addr           = '0;
    core_wdata          = '0;
    app_rdy             = 1'b0;
    app_wdf_rdy         = 1'b0;
    app_rd_data_valid   = 1'b0;
    app_rd_data         = '0;
    repeat (3) tick();
    check_zero("reset");
    reset = 1'b0;

    // Calibration gate: core 0 waits until calibration completes.
    core_addr[31:0] = 32'h0000_0100;
    core_req        = 16'h0001;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("calib_en", app_en, 0);
      chk("calib_busy", busy, 0);
    end
    init_calib_complete = 1'b1;
    tick();
    chk("calib_arb_en", app_en, 0);
    run_txn(16'h0001, 0, 0, 0, {4{32'h1111_2222}}, got);
    chk("calib_grant", got, 0);

    // Read lane select.
    core_wren[3]          = 1'b0;
    core_addr[32*3 +: 32] = 32'h0000_1238;
    run_txn(16'h0008, 1, 0, 1, {32'hcafecafe, 32'hfaceface, 32'hbabebabe, 32'hbeadbead}, got);
    chk("lane_addr", app_addr, 28'h0000_918);
    chk("lane_cmd", app_cmd, 1);
    chk("lane_rdata", core_rdata, 32'hfaceface);

    // Write with split handshakes.
    core_wren[5]           = 1'b1;
    core_addr[32*5 +: 32]  = 32'h0000_0044;
    core_wdata[32*5 +: 32] = 32'hdeadbeef;
    run_txn(16'h0020, 3, 1, 0, '0, got);
    chk("split_mask", app_wdf_mask, 16'hFF0F);
    chk("split_data", app_wdf_data, {4{32'hdeadbeef}});

    // Round-robin fairness from a fresh pointer.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_ptr = 0;
    tick();
    for (int i = 0; i < N + 1; i++) begin
      run_txn('1, 0, 0, 0, {$urandom(), $urandom(), $urandom(), $urandom()}, got);
      chk("rr_order", got, i % N);
    end

    // Stray read data in ARB.
    core_req          = '0;
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    chk("stray_resp", core_resp, 0);
    chk("stray_busy", busy, 0);
    tick();
    chk("stray_resp2", core_resp, 0);

    // Reset during WAIT_RD aborts the read.
    core_wren[7] = 1'b0;
    core_req     = 16'h0080;
    tick();
    chk("abort_grant", grant_id, 7);
    chk("abort_en", app_en, 1);
    app_rdy = 1'b1;
    tick();
    app_rdy = 1'b0;
    chk("abort_wait_en", app_en, 0);
    tick();
    reset             = 1'b1;
    app_rd_data_valid = 1'b1;
    app_rd_data       = {4{32'h5a5a_a5a5}};
    tick();
    check_zero("abort");
    reset             = 1'b0;
    app_rd_data_valid = 1'b0;
    tick();
    chk("abort_init_en", app_en, 0);
    chk("abort_init_busy", busy, 0);
    chk("abort_init_resp", core_resp, 0);
    m_ptr = 0;
    run_txn(16'h0080, 0, 0, 0, {$urandom(), $urandom(), $urandom(), $urandom()}, got);
    chk("abort_regrant", got, 7);

    // Sparse requests with pointer wrap-around.
    run_txn(16'h2000, 0, 0, 0, '0, got);
    chk("sparse_13", got, 13);
    run_txn(16'h0004, 0, 0, 0, '0, got);
    chk("sparse_wrap", got, 2);
    run_txn(16'h000C, 0, 0, 0, '0, got);
    chk("sparse_ptr3", got, 3);

    // Randomized traffic.
    for (int t = 0; t < 60; t++) begin
      int idle;
      logic [N-1:0] rq;
      idle = $urandom_range(0, 2);
      for (int i = 0; i < idle; i++) begin
        core_req          = '0;
        app_rd_data_valid = 1'($urandom_range(0, 1));
        tick();
        app_rd_data_valid = 1'b0;
        chk("idle_busy", busy, 0);
        chk("idle_resp", core_resp, 0);
        chk("idle_en", app_en, 0);
      end
      scramble();
      rq = N'($urandom());
      if (rq == '0) rq[$urandom_range(0, N - 1)] = 1'b1;
      run_txn(rq, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              {$urandom(), $urandom(), $urandom(), $urandom()}, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
